// File: rtl/hazard_pkg.sv
// Shared widths, encodings and the per-source hazard rule for the pipeline hazard controller.
package hazard_pkg;

    localparam int TUSE_W = 2;
    localparam int TNEW_W = 2;
    localparam int REG_W  = 5;

    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    typedef enum logic {
        MD_MULT = 1'b0,
        MD_DIV  = 1'b1
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // A source register conflicts when a producer in E or M will not have its result
    // ready by the time D needs it; $0 is hardwired and never conflicts.
    function automatic logic src_hazard(
        input logic [REG_W-1:0]  src,
        input logic [TUSE_W-1:0] tuse,
        input logic [REG_W-1:0]  wa_e,
        input logic [TNEW_W-1:0] tnew_e,
        input logic [REG_W-1:0]  wa_m,
        input logic [TNEW_W-1:0] tnew_m
    );
        logic hit;
        hit = 1'b0;
        if (src != '0 && tuse != TUSE_NONE) begin
            hit = ((src == wa_e) && (tnew_e > tuse)) ||
                  ((src == wa_m) && (tnew_m > tuse));
        end
        return hit;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// Mult/div busy timer: loads the op latency on start and counts down to idle.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cnt_next   = (md_op_e'(is_div) == MD_DIV) ? CNT_W'(DIV_CYCLES)
                                                              : CNT_W'(MULT_CYCLES);
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A start arriving here is ignored; the timer is never reloaded mid-op.
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_reg == ST_BUSY);
    end

    a_no_start_while_busy: assert property (@(posedge clk) disable iff (!clr_n)
        !(start && busy));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: data-hazard compare, mult/div busy interlock, optional stall counter.
// Define HAZARD_STATS_EN to build the saturating stall-cycle counter on stall_cnt.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [REG_W-1:0]  rs_D,
    input  logic [REG_W-1:0]  rt_D,
    input  logic [TUSE_W-1:0] tuse_rs_D,
    input  logic [TUSE_W-1:0] tuse_rt_D,
    input  logic              md_use_D,
    input  logic [REG_W-1:0]  wa_E,
    input  logic [TNEW_W-1:0] tnew_E,
    input  logic [REG_W-1:0]  wa_M,
    input  logic [TNEW_W-1:0] tnew_M,
    input  logic              md_start_E,
    input  logic              md_div_E,
    output logic              stall_F,
    output logic              stall_D,
    output logic              flush_E,
    output logic              md_busy,
    output logic [31:0]       stall_cnt
);

    logic haz_rs, haz_rt, haz_md, stall;

    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk   (clk),
        .clr_n (clr_n),
        .start (md_start_E),
        .is_div(md_div_E),
        .busy  (md_busy)
    );

    always_comb begin
        haz_rs = src_hazard(rs_D, tuse_rs_D, wa_E, tnew_E, wa_M, tnew_M);
        haz_rt = src_hazard(rt_D, tuse_rt_D, wa_E, tnew_E, wa_M, tnew_M);
        // The start cycle itself must stall too, since md_busy only rises on the next edge.
        haz_md = md_use_D && (md_busy || md_start_E);
        stall  = haz_rs || haz_rt || haz_md;
    end

    assign stall_F = stall;
    assign stall_D = stall;
    assign flush_E = stall;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stall_cnt_reg <= '0;
        end else if (stall && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule
